// File: rtl/fetch_frontend.sv
// Instruction-fetch front end: PC register, IF/ID pipeline register and
// saturating stall/flush counters, with load-use hold and ID-stage redirect.
module fetch_frontend #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_inst_i,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_inst_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [31:0]      pc_r, pc_s;
  logic [31:0]      if_id_pc_r, if_id_pc_s;
  logic [31:0]      if_id_inst_r, if_id_inst_s;
  logic             if_id_valid_r, if_id_valid_s;
  logic [CNT_W-1:0] stall_cnt_r, stall_cnt_s;
  logic [CNT_W-1:0] flush_cnt_r, flush_cnt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  // Next-state and next-register computation; priority stall > redirect > advance.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    if_id_pc_s    = if_id_pc_r;
    if_id_inst_s  = if_id_inst_r;
    if_id_valid_s = if_id_valid_r;
    stall_cnt_s   = stall_cnt_r;
    flush_cnt_s   = flush_cnt_r;
    case (state_r)
      IDLE: begin
        // The start edge itself does not latch IF/ID.
        if (start_i) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // Branch is ignored under stall: ID operands are stale and get re-presented.
        if (stall_i) begin
          stall_cnt_s = sat_inc(stall_cnt_r);
        end else if (branch_taken_i) begin
          pc_s          = {branch_target_i[31:2], 2'b00};
          if_id_pc_s    = pc_r;
          if_id_inst_s  = NOP_INST;
          if_id_valid_s = 1'b0;
          flush_cnt_s   = sat_inc(flush_cnt_r);
        end else begin
          pc_s          = pc_r + 32'd4;
          if_id_pc_s    = pc_r;
          if_id_inst_s  = imem_inst_i;
          if_id_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_inst_r  <= NOP_INST;
      if_id_valid_r <= 1'b0;
      stall_cnt_r   <= '0;
      flush_cnt_r   <= '0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      if_id_pc_r    <= if_id_pc_s;
      if_id_inst_r  <= if_id_inst_s;
      if_id_valid_r <= if_id_valid_s;
      stall_cnt_r   <= stall_cnt_s;
      flush_cnt_r   <= flush_cnt_s;
    end
  end

  assign imem_addr_o   = pc_r;
  assign if_id_pc_o    = if_id_pc_r;
  assign if_id_inst_o  = if_id_inst_r;
  assign if_id_valid_o = if_id_valid_r;
  assign stall_cnt_o   = stall_cnt_r;
  assign flush_cnt_o   = flush_cnt_r;

endmodule

// File: tb/tb_fetch_frontend.sv
// Directed bench for fetch_frontend: a reference model pushes expected state to a
// scoreboard queue per edge; directed constant checks cover the named scenarios.
module tb_fetch_frontend;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             rst, start, stall, br;
  logic [31:0]      tgt;
  logic [31:0]      imem_addr, imem_inst;
  logic [31:0]      if_id_pc, if_id_inst;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  fetch_frontend #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt), .imem_addr_o(imem_addr),
    .imem_inst_i(imem_inst), .if_id_pc_o(if_id_pc), .if_id_inst_o(if_id_inst),
    .if_id_valid_o(if_id_valid), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;
  assign imem_inst = 32'hAAAA_0000 + imem_addr;

  typedef struct {
    string            tag;
    logic [31:0]      addr, pc, inst;
    logic             valid;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;
  exp_t sb[$];

  logic             m_run;
  logic [31:0]      m_pc, m_ipc, m_inst;
  logic             m_v;
  logic [CNT_W-1:0] m_sc, m_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic st,
                      input logic b, input logic [31:0] t);
    exp_t e;
    rst = r; start = s; stall = st; br = b; tgt = t;
    if (r) begin
      m_run = 1'b0; m_pc = 32'h0; m_ipc = 32'h0; m_inst = 32'h13; m_v = 1'b0;
      m_sc = '0; m_fc = '0;
    end else if (!m_run) begin
      if (s) m_run = 1'b1;
    end else if (st) begin
      if (m_sc != CMAX) m_sc = m_sc + 1'b1;
    end else if (b) begin
      m_ipc = m_pc; m_inst = 32'h13; m_v = 1'b0;
      m_pc = t & 32'hFFFF_FFFC;
      if (m_fc != CMAX) m_fc = m_fc + 1'b1;
    end else begin
      m_ipc = m_pc; m_inst = 32'hAAAA_0000 + m_pc; m_v = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    e.tag = tag; e.addr = m_pc; e.pc = m_ipc; e.inst = m_inst; e.valid = m_v;
    e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".addr"}, imem_addr, e.addr);
    chk({e.tag, ".pc"}, if_id_pc, e.pc);
    chk({e.tag, ".inst"}, if_id_inst, e.inst);
    chk({e.tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
    chk({e.tag, ".scnt"}, {{(32-CNT_W){1'b0}}, stall_cnt}, {{(32-CNT_W){1'b0}}, e.sc});
    chk({e.tag, ".fcnt"}, {{(32-CNT_W){1'b0}}, flush_cnt}, {{(32-CNT_W){1'b0}}, e.fc});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    @(negedge clk);
    step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.inst", if_id_inst, 32'h0000_0013);
    chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
    step("idle_ign", 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    step("start", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("start.valid", {31'd0, if_id_valid}, 32'd0);
    for (int i = 0; i < 3; i++) step("fetch", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("start.pc", if_id_pc, 32'h8);
    chk("start.inst", if_id_inst, 32'hAAAA_0008);
    chk("start.addr", imem_addr, 32'hC);
    step("to10", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall.addr", imem_addr, 32'h10);
    chk("stall.cnt", {28'd0, stall_cnt}, 32'd3);
    step("unstall", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("unstall.inst", if_id_inst, 32'hAAAA_0010);
    for (int i = 0; i < 3; i++) step("to20", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("redir", 1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
    chk("redir.addr", imem_addr, 32'h100);
    chk("redir.inst", if_id_inst, 32'h13);
    chk("redir.fcnt", {28'd0, flush_cnt}, 32'd1);
    step("redir_n", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_n.pc", if_id_pc, 32'h100);
    chk("redir_n.valid", {31'd0, if_id_valid}, 32'd1);
    step("stall_br", 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    chk("stall_br.addr", imem_addr, 32'h104);
    chk("stall_br.fcnt", {28'd0, flush_cnt}, 32'd1);
    step("br200", 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    chk("br200.addr", imem_addr, 32'h200);
    step("b2b0", 1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
    step("b2b1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
    chk("b2b.pc", if_id_pc, 32'h300);
    chk("b2b.fcnt", {28'd0, flush_cnt}, 32'd4);
    step("start_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step("to_top", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("top.addr", imem_addr, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.pc", if_id_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) step("sc_fill", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("sc_fill", {28'd0, stall_cnt}, 32'd14);
    for (int i = 0; i < 3; i++) step("sc_sat", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("sc_sat", {28'd0, stall_cnt}, 32'd15);
    for (int i = 0; i < 11; i++) step("fc_sat", 1'b0, 1'b0, 1'b0, 1'b1, 32'h10 * i);
    chk("fc_sat", {28'd0, flush_cnt}, 32'd15);
    step("rst_mid", 1'b1, 1'b0, 1'b1, 1'b1, 32'h500);
    chk("rst_mid.scnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_mid.inst", if_id_inst, 32'h13);
    step("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("idle_br", 1'b0, 1'b0, 1'b0, 1'b1, 32'h600);
    chk("idle.addr", imem_addr, 32'h0);
    chk("idle.fcnt", {28'd0, flush_cnt}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_frontend.md
Name: fetch_frontend

Overview:
- Instruction-fetch front end of the 5-stage RISC-V pipeline: holds the PC and the IF/ID pipeline register, and drives the instruction-memory address.
- It is the consumer of the load-use stall produced by hazard detection and of the branch redirect resolved in ID. It applies hold, flush (bubble insertion) and redirect cycle-accurately.
- It also keeps saturating stall and flush counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) written into IF/ID on flush and reset.
- CNT_W, 32, width of stall/flush counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- stall_i  in  1  load-use stall from hazard detection: hold PC and IF/ID.
- branch_taken_i  in  1  branch/jump resolved taken in ID this cycle.
- branch_target_i  in  32  redirect target from ID.
- imem_addr_o  out  32  instruction-memory address, equals pc_q combinationally.
- imem_inst_i  in  32  instruction word for imem_addr_o, combinational (same-cycle) memory.
- if_id_pc_o  out  32  PC of the instruction held in IF/ID.
- if_id_inst_o  out  32  instruction held in IF/ID.
- if_id_valid_o  out  1  1 = real instruction, 0 = bubble.
- stall_cnt_o  out  CNT_W  cycles in RUN with stall_i=1, saturating.
- flush_cnt_o  out  CNT_W  accepted redirects, saturating.

Behaviour:
- States: IDLE, RUN. Registered state; rst_i forces IDLE.
- Reset (rst_i=1 at edge, any state, overrides all other inputs):
  - pc_q=RESET_PC
  - if_id_pc_o=0, if_id_inst_o=NOP_INST, if_id_valid_o=0
  - stall_cnt_o=0, flush_cnt_o=0
- IDLE:
  - imem_addr_o=pc_q; PC and IF/ID hold; counters hold.
  - stall_i and branch_taken_i are ignored.
  - start_i=1 at an edge: next state RUN. That transition edge does not latch IF/ID; the first fetch is latched at the first edge in RUN.
- RUN, evaluated per edge with priority stall > redirect > advance:
  - stall_i=1: pc_q and all IF/ID fields hold; stall_cnt_o += 1 unless all-ones. branch_taken_i is ignored, because the ID-stage operands are stale during a load-use stall; ID re-presents the branch next cycle.
  - stall_i=0, branch_taken_i=1:
    - pc_q <= {branch_target_i[31:2],2'b00}; target bits [1:0] are always cleared.
    - IF/ID <= {pc=pc_q, inst=NOP_INST, valid=0}; the wrong-path fetch is discarded.
    - flush_cnt_o += 1 unless all-ones.
  - Otherwise: IF/ID <= {pc_q, imem_inst_i, 1}; pc_q <= pc_q+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- start_i in RUN: ignored; only rst_i returns to IDLE.
- Latency:
  - Instruction at address A appears on if_id_* one edge after imem_addr_o=A, provided that edge is not a stall or redirect edge.
  - A redirect accepted at edge N: target appears on imem_addr_o after edge N; the target instruction is in IF/ID after edge N+1. Penalty is exactly one bubble.
- Back-to-back redirects on consecutive unstalled edges: each one is applied and counted, and each inserts one bubble.
- Counters never wrap; once all-ones they hold.
- Every output is a pure function of registered state, except imem_addr_o, which is pc_q passed through directly.

Test Plan:
- Reset then start:
  - rst_i=1 for 2 cycles: pc_q=0, if_id_inst_o=0x00000013, valid=0, counters 0.
  - start_i=1 for 1 cycle: after 1 edge state RUN and IF/ID unchanged; then imem returns 0xAAAA0000+addr; after 3 more edges if_id_pc_o=8, if_id_inst_o=0xAAAA0008, imem_addr_o=0xC.
- Stall hold: in RUN at pc_q=0x10, stall_i=1 for 3 edges: imem_addr_o stays 0x10, IF/ID unchanged, stall_cnt_o=3; first unstalled edge latches inst@0x10.
- Redirect: at pc_q=0x20, branch_taken_i=1, target=0x103:
  - next: imem_addr_o=0x100, if_id_valid_o=0, if_id_inst_o=0x13, flush_cnt_o=1.
  - following edge: if_id_pc_o=0x100, valid=1.
- Stall masks branch: stall_i=1 and branch_taken_i=1 (target 0x200) on the same edge: pc_q unchanged, flush_cnt_o unchanged, stall_cnt_o +1. Next edge with stall_i=0 and branch_taken_i=1: redirect to 0x200.
- Boundary:
  - pc_q=0xFFFF_FFFC advance: pc_q becomes 0 and if_id_pc_o=0xFFFF_FFFC.
  - Force stall_cnt_o to all-ones-1, stall 3 edges: holds at all-ones.
  - rst_i asserted mid-stall with branch_taken_i=1: full reset values, state IDLE.
